// File: rtl/data_mem_ctrl.sv
// Data-memory controller between the core and a handshaked RAM.
// Stores are posted into a small circular write buffer and drained to RAM in
// order. Loads that hit the buffer are forwarded from the youngest matching
// entry; load misses wait until the buffer is empty and then issue a RAM read.
module data_mem_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WR,
    input  logic        MemtoReg,
    input  logic [7:0]  address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        ram_req,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WR_BUSY,
        RD_BUSY
    } state_t;

    state_t            state;

    logic [7:0]        buf_addr [DEPTH];
    logic [31:0]       buf_data [DEPTH];
    logic [DEPTH-1:0]  buf_valid;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [31:0]       rd_hold;

    logic              load_req;
    logic              full;
    logic              push;
    logic              pop;
    logic              rd_done;
    logic              hit;
    logic [31:0]       hit_data;
    logic [PW-1:0]     scan_idx;

    // MemtoReg is ignored whenever a store is requested.
    assign load_req = MemtoReg && !WR;
    // Fullness comes from the registered count, so a pop in the same cycle
    // cannot make room for the incoming store.
    assign full     = (count == CW'(DEPTH));
    assign push     = rst && WR && !full;
    assign pop      = (state == WR_BUSY) && ram_ack;
    assign rd_done  = (state == RD_BUSY) && ram_ack;

    // Scan the buffer oldest-to-youngest so the youngest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (buf_valid[scan_idx] && (buf_addr[scan_idx] == address)) begin
                hit      = 1'b1;
                hit_data = buf_data[scan_idx];
            end
        end
    end

    // Stall on a store to a full buffer, or on a load that neither hits the
    // buffer nor completes this cycle; never stall while reset is asserted.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = 1'b0;
        end else if (WR) begin
            stall = full;
        end else if (MemtoReg && !hit) begin
            stall = !rd_done;
        end
    end

    // Forwarded hit data or RAM data in the ack cycle, else the last returned value.
    always_comb begin
        readData = rd_hold;
        if (load_req && hit) begin
            readData = hit_data;
        end else if (load_req && rd_done) begin
            readData = ram_rdata;
        end
    end

    // Buffer control: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            buf_valid <= '0;
        end else begin
            if (push) begin
                tail            <= tail + PW'(1);
                buf_valid[tail] <= 1'b1;
            end
            if (pop) begin
                head            <= head + PW'(1);
                buf_valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer payload storage; contents are meaningless unless the valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= address;
            buf_data[tail] <= writeData;
        end
    end

    // Registered copy of the last value returned to the core.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_hold <= '0;
        end else if (load_req && (hit || rd_done)) begin
            rd_hold <= readData;
        end
    end

    // RAM sequencer: drain has priority over loads, and IDLE is always
    // revisited between transactions so ram_req drops for at least one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= buf_addr[head];
                        ram_wdata <= buf_data[head];
                        state     <= WR_BUSY;
                    end else if (push) begin
                        // Empty buffer: the entry being pushed is the head.
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= address;
                        ram_wdata <= writeData;
                        state     <= WR_BUSY;
                    end else if (load_req && !hit) begin
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= address;
                        state     <= RD_BUSY;
                    end
                end
                WR_BUSY: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RD_BUSY: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        ram_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    ram_req <= 1'b0;
                    ram_we  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
